// File: rtl/ula_arbiter_pkg.sv
// Shared definitions for ula_arbiter: op-code constants, FSM state type and default datapath width.
package ula_arb_pkg;

    localparam int DATA_W_DEF = 8;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/ula_arbiter_if.sv
// Request/response bus between the two requesters and ula_arbiter; the arbiter uses the slave modport.
interface ula_arbiter_if
    import ula_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [2*DATA_W-1:0] req_a;
    logic [2*DATA_W-1:0] req_b;
    logic [5:0]          req_op;
    logic [1:0]          rsp_valid;
    logic [1:0]          rsp_ready;
    logic [DATA_W-1:0]   rsp_result;
    logic                rsp_z;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_z
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_z
    );
endinterface

// File: rtl/ula_arbiter_rr_arb2.sv
// Combinational 2-way round-robin grant; the pointer register lives in the parent.
module rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_ptr,
    output logic [1:0] o_gnt
);

    // A lone requester always wins; the pointer only breaks ties.
    always_comb begin
        o_gnt = i_req;
        if (&i_req) begin
            o_gnt = i_ptr ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/ula_arbiter.sv
// Two-requester round-robin arbiter sharing one registered ALU, one operation in flight.
// Optional per-requester saturating grant counters are enabled by defining ULA_ARB_STATS_EN.
module ula_arbiter
    import ula_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NREQ   = 2
`ifdef ULA_ARB_STATS_EN
    ,
    parameter int CNT_W  = 16
`endif
)(
    input  logic              clk,
    input  logic              rst_n,
    ula_arbiter_if.slave      bus
`ifdef ULA_ARB_STATS_EN
    ,
    output logic [2*CNT_W-1:0] grant_cnt
`endif
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_EXEC = EXEC;
    localparam logic [1:0] ST_RESP = RESP;

    logic [1:0]        r_state;
    logic              r_ptr;
    logic              r_owner;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [2:0]        r_op;
    logic [DATA_W-1:0] r_result;
    logic              r_z;

    logic [NREQ-1:0]   w_req;
    logic [NREQ-1:0]   w_gnt;
    logic              w_accept;
    logic              w_gnt_idx;
    logic [DATA_W-1:0] w_alu;
    logic              w_rsp_hs;

    function automatic logic [DATA_W-1:0] aluEval(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input logic [2:0]        op
    );
        logic [DATA_W-1:0] res;
        case (op)
            OP_ADD:  res = a + b;
            OP_SUB:  res = a - b;
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_SLT:  res = {{(DATA_W-1){1'b0}}, (a < b)};
            default: res = '0;
        endcase
        return res;
    endfunction

    // Requests are only visible to the arbiter while idle, so req_ready is zero in EXEC/RESP.
    assign w_req = (r_state == ST_IDLE) ? bus.req_valid : '0;

    rr_arb2 u_rr_arb2 (
        .i_req (w_req),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt)
    );

    assign w_accept      = |w_gnt;
    assign w_gnt_idx     = w_gnt[1];
    assign bus.req_ready = w_gnt;

    assign w_alu    = aluEval(r_a, r_b, r_op);
    assign w_rsp_hs = (r_state == ST_RESP) && bus.rsp_ready[r_owner];

    assign bus.rsp_valid  = (r_state != ST_RESP) ? 2'b00 : (r_owner ? 2'b10 : 2'b01);
    assign bus.rsp_result = r_result;
    assign bus.rsp_z      = r_z;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_ptr    <= 1'b0;
            r_owner  <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_result <= '0;
            r_z      <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_owner <= w_gnt_idx;
                        r_ptr   <= ~w_gnt_idx;
                        r_a     <= bus.req_a[w_gnt_idx*DATA_W +: DATA_W];
                        r_b     <= bus.req_b[w_gnt_idx*DATA_W +: DATA_W];
                        r_op    <= bus.req_op[w_gnt_idx*3 +: 3];
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_result <= w_alu;
                    r_z      <= (w_alu == '0);
                    r_state  <= ST_RESP;
                end
                ST_RESP: begin
                    if (w_rsp_hs) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef ULA_ARB_STATS_EN
    logic [CNT_W-1:0] r_cnt [NREQ];

    // A grant is exactly a request handshake; counters stick at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (w_gnt[i] && (r_cnt[i] != '1)) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign grant_cnt = {r_cnt[1], r_cnt[0]};
`endif

endmodule

// File: tb/tb_ula_arbiter.sv
// Self-checking bench for ula_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_ula_arbiter;
    import ula_arb_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    ula_arbiter_if #(.DATA_W(8)) bus ();

    int checks   = 0;
    int failures = 0;
    int rrNext;
    int refCnt [2];

`ifdef ULA_ARB_STATS_EN
    logic [31:0] grantCnt;
    logic [3:0]  grantCnt2;
    ula_arbiter_if #(.DATA_W(8)) bus2 ();

    ula_arbiter #(.DATA_W(8), .NREQ(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .grant_cnt(grantCnt)
    );
    ula_arbiter #(.DATA_W(8), .NREQ(2), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2), .grant_cnt(grantCnt2)
    );
`else
    ula_arbiter #(.DATA_W(8), .NREQ(2)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
`endif

    // Reference ALU written from the op-code table with plain integer arithmetic.
    function automatic logic [7:0] refAlu(input int a, input int b, input int op);
        int r;
        case (op)
            0: r = (a + b) % 256;
            1: r = (a - b + 256) % 256;
            2: r = a & b;
            3: r = a | b;
            5: r = (a < b) ? 1 : 0;
            default: r = 0;
        endcase
        return 8'(r);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearBus();
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b00;
    endtask

    task automatic modelReset();
        rrNext    = 0;
        refCnt[0] = 0;
        refCnt[1] = 0;
    endtask

    task automatic applyReset();
        clearBus();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        modelReset();
        tick();
    endtask

    // Runs one full request/response transaction and checks it against the model.
    task automatic doTxn(input string tag, input logic [1:0] mask,
                         input logic [7:0] a0, input logic [7:0] b0, input logic [2:0] op0,
                         input logic [7:0] a1, input logic [7:0] b1, input logic [2:0] op1,
                         input int hold, input logic [1:0] noise, output int g);
        logic [1:0] expBit;
        logic [7:0] expRes;
        int waitN;
        g = -1;
        bus.req_valid = mask;
        bus.req_a     = {a1, a0};
        bus.req_b     = {b1, b0};
        bus.req_op    = {op1, op0};
        bus.rsp_ready = 2'b00;
        #1;
        waitN = 0;
        while (bus.req_ready == 2'b00 && waitN < 20) begin
            tick();
            waitN++;
        end
        checks++;
        if (bus.req_ready == 2'b00) begin
            failures++;
            $display("[TB] FAIL %s grant_timeout got=%b exp=nonzero", tag, bus.req_ready);
            clearBus();
            return;
        end
        g      = (mask == 2'b11) ? rrNext : (mask[1] ? 1 : 0);
        expBit = (g == 1) ? 2'b10 : 2'b01;
        expRes = (g == 1) ? refAlu(a1, b1, op1) : refAlu(a0, b0, op0);
        checks++;
        if (bus.req_ready !== expBit) begin
            failures++;
            $display("[TB] FAIL %s req_ready got=%b exp=%b", tag, bus.req_ready, expBit);
        end
        tick();
        rrNext = 1 - g;
        if (refCnt[g] < 65535) refCnt[g]++;
        checks++;
        if (bus.rsp_valid !== 2'b00 || bus.req_ready !== 2'b00) begin
            failures++;
            $display("[TB] FAIL %s exec_outputs got=%b/%b exp=00/00", tag, bus.rsp_valid, bus.req_ready);
        end
        tick();
        checks++;
        if (bus.rsp_valid !== expBit || bus.rsp_result !== expRes || bus.rsp_z !== (expRes == 8'd0)
            || bus.req_ready !== 2'b00) begin
            failures++;
            $display("[TB] FAIL %s response got=%b/%0d/%b exp=%b/%0d/%b", tag, bus.rsp_valid,
                     bus.rsp_result, bus.rsp_z, expBit, expRes, (expRes == 8'd0));
        end
        for (int h = 0; h < hold; h++) begin
            bus.rsp_ready = noise & ~expBit;
            tick();
            checks++;
            if (bus.rsp_valid !== expBit || bus.rsp_result !== expRes || bus.req_ready !== 2'b00) begin
                failures++;
                $display("[TB] FAIL %s hold got=%b/%0d exp=%b/%0d", tag, bus.rsp_valid,
                         bus.rsp_result, expBit, expRes);
            end
        end
        bus.rsp_ready = expBit | noise;
        tick();
        bus.rsp_ready = 2'b00;
        checks++;
        if (bus.rsp_valid !== 2'b00) begin
            failures++;
            $display("[TB] FAIL %s after_handshake got=%b exp=00", tag, bus.rsp_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clearBus();
        bus.req_a  = '0;
        bus.req_b  = '0;
        bus.req_op = '0;
        tick();
        checks++;
        if (bus.rsp_valid !== 2'b00 || bus.req_ready !== 2'b00 || bus.rsp_result !== 8'd0 || bus.rsp_z !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_values got=%b/%b/%0d/%b exp=00/00/0/1", bus.rsp_valid,
                     bus.req_ready, bus.rsp_result, bus.rsp_z);
        end
        rst_n = 1'b1;
        modelReset();
        tick();
    endtask

    task automatic test_single();
        int g;
        doTxn("single", 2'b01, 8'd200, 8'd100, OP_ADD, 8'd0, 8'd0, OP_ADD, 3, 2'b00, g);
        clearBus();
        tick();
    endtask

    task automatic test_flags();
        int g;
        doTxn("flag_sub", 2'b10, 8'd0, 8'd0, OP_ADD, 8'd5, 8'd5, OP_SUB, 0, 2'b00, g);
        doTxn("flag_slt", 2'b10, 8'd0, 8'd0, OP_ADD, 8'd3, 8'd7, OP_SLT, 1, 2'b00, g);
        doTxn("flag_bad", 2'b10, 8'd0, 8'd0, OP_ADD, 8'd9, 8'd4, 3'b110, 0, 2'b00, g);
        clearBus();
        tick();
    endtask

    task automatic test_contention();
        int g;
        applyReset();
        for (int i = 0; i < 4; i++) begin
            doTxn("contention", 2'b11, 8'd1, 8'd2, OP_ADD, 8'd12, 8'd10, OP_AND, 1, 2'b00, g);
            checks++;
            if (g != (i % 2)) begin
                failures++;
                $display("[TB] FAIL contention_order got=%0d exp=%0d", g, i % 2);
            end
        end
        clearBus();
        tick();
    endtask

    task automatic test_non_owner();
        int g;
        doTxn("non_owner", 2'b01, 8'd40, 8'd2, OP_OR, 8'd0, 8'd0, OP_ADD, 3, 2'b10, g);
        clearBus();
        tick();
    endtask

    task automatic test_back_to_back();
        int g;
        doTxn("b2b_first", 2'b01, 8'd10, 8'd3, OP_SUB, 8'd0, 8'd0, OP_ADD, 0, 2'b00, g);
        #1;
        checks++;
        if (bus.req_ready !== 2'b01) begin
            failures++;
            $display("[TB] FAIL b2b_regrant got=%b exp=01", bus.req_ready);
        end
        doTxn("b2b_second", 2'b01, 8'd250, 8'd10, OP_ADD, 8'd0, 8'd0, OP_ADD, 0, 2'b00, g);
        clearBus();
        tick();
    endtask

    task automatic test_reset_mid();
        int g;
        bus.req_valid = 2'b01;
        bus.req_a     = {8'd0, 8'd7};
        bus.req_b     = {8'd0, 8'd9};
        bus.req_op    = {3'b000, OP_ADD};
        tick();
        bus.req_valid = 2'b00;
        tick();
        checks++;
        if (bus.rsp_valid !== 2'b01) begin
            failures++;
            $display("[TB] FAIL reset_mid_pre got=%b exp=01", bus.rsp_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checks++;
        if (bus.rsp_valid !== 2'b00 || bus.rsp_z !== 1'b1 || bus.rsp_result !== 8'd0) begin
            failures++;
            $display("[TB] FAIL reset_mid_async got=%b/%b/%0d exp=00/1/0", bus.rsp_valid,
                     bus.rsp_z, bus.rsp_result);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.rsp_ready = 2'b11;
            tick();
            checks++;
            if (bus.rsp_valid !== 2'b00) begin
                failures++;
                $display("[TB] FAIL reset_mid_quiet got=%b exp=00", bus.rsp_valid);
            end
        end
        bus.rsp_ready = 2'b00;
        doTxn("reset_mid_ptr", 2'b11, 8'd6, 8'd6, OP_SUB, 8'd1, 8'd1, OP_OR, 0, 2'b00, g);
        clearBus();
        tick();
    endtask

    task automatic test_random();
        int g;
        for (int i = 0; i < 40; i++) begin
            doTxn("random", 2'($urandom_range(1, 3)),
                  8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
                  8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
                  $urandom_range(0, 2), 2'($urandom_range(0, 3)), g);
            if ($urandom_range(0, 3) == 0) begin
                clearBus();
                tick();
            end
        end
        clearBus();
        tick();
    endtask

`ifdef ULA_ARB_STATS_EN
    task automatic test_stats();
        int g;
        int sat;
        int waitN;
        applyReset();
        for (int i = 0; i < 5; i++) begin
            doTxn("stats_r0", 2'b01, 8'(i), 8'd1, OP_ADD, 8'd0, 8'd0, OP_ADD, 0, 2'b00, g);
        end
        for (int i = 0; i < 3; i++) begin
            doTxn("stats_r1", 2'b10, 8'd0, 8'd0, OP_ADD, 8'(i), 8'd2, OP_OR, 0, 2'b00, g);
        end
        clearBus();
        checks++;
        if (grantCnt[15:0] !== 16'(refCnt[0]) || grantCnt[31:16] !== 16'(refCnt[1])) begin
            failures++;
            $display("[TB] FAIL stats_counts got=%0d/%0d exp=%0d/%0d", grantCnt[15:0],
                     grantCnt[31:16], refCnt[0], refCnt[1]);
        end
        sat = 0;
        bus2.req_a  = '0;
        bus2.req_b  = '0;
        bus2.req_op = '0;
        for (int k = 0; k < 6; k++) begin
            bus2.req_valid = 2'b01;
            #1;
            waitN = 0;
            while (bus2.req_ready != 2'b01 && waitN < 20) begin
                tick();
                waitN++;
            end
            tick();
            bus2.req_valid = 2'b00;
            if (sat < 3) sat++;
            tick();
            tick();
            bus2.rsp_ready = 2'b01;
            tick();
            bus2.rsp_ready = 2'b00;
        end
        checks++;
        if (grantCnt2[1:0] !== 2'(sat) || grantCnt2[3:2] !== 2'd0) begin
            failures++;
            $display("[TB] FAIL stats_saturate got=%0d/%0d exp=%0d/0", grantCnt2[1:0], grantCnt2[3:2], sat);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
`ifdef ULA_ARB_STATS_EN
        bus2.req_valid = 2'b00;
        bus2.rsp_ready = 2'b00;
        bus2.req_a     = '0;
        bus2.req_b     = '0;
        bus2.req_op    = '0;
`endif
        test_reset();
        test_single();
        test_flags();
        test_contention();
        test_non_owner();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef ULA_ARB_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
